// File: rtl/ram_arbiter2.sv
// Two-port round-robin arbiter in front of a single-port RAM with 2-cycle read latency.
// Read results are routed back to the requesting port via a 2-stage tag pipeline.
module ram_arbiter2 #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  output logic                 a_ack,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,

  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_wdata,
  output logic                 b_ack,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata,

  output logic [ADDR_BITS-1:0] ram_address,
  output logic                 ram_wren,
  output logic [WIDTH-1:0]     ram_write_data,
  input  logic [WIDTH-1:0]     ram_read_data
);

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic last_grant;
  logic grant_a;
  logic grant_b;

  // Tag pipeline: owner 0 = port A, 1 = port B.
  logic s1_valid;
  logic s1_owner;
  logic s2_valid;
  logic s2_owner;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        grant_a = (last_grant == LAST_B);
        grant_b = (last_grant == LAST_A);
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_ack = grant_a;
  assign b_ack = grant_b;

  always_comb begin
    ram_address    = '0;
    ram_wren       = 1'b0;
    ram_write_data = '0;
    if (grant_a) begin
      ram_address    = a_addr;
      ram_wren       = a_we;
      ram_write_data = a_wdata;
    end else if (grant_b) begin
      ram_address    = b_addr;
      ram_wren       = b_we;
      ram_write_data = b_wdata;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      last_grant <= LAST_B;
      s1_valid   <= 1'b0;
      s1_owner   <= 1'b0;
      s2_valid   <= 1'b0;
      s2_owner   <= 1'b0;
    end else begin
      if (grant_a) begin
        last_grant <= LAST_A;
      end else if (grant_b) begin
        last_grant <= LAST_B;
      end
      s1_valid <= (grant_a && !a_we) || (grant_b && !b_we);
      s1_owner <= grant_b;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
    end
  end

  assign a_rvalid = s2_valid && !s2_owner;
  assign b_rvalid = s2_valid &&  s2_owner;
  assign a_rdata  = a_rvalid ? ram_read_data : '0;
  assign b_rdata  = b_rvalid ? ram_read_data : '0;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Scoreboard bench for ram_arbiter2: a driver predicts grants and read results from
// arbitration rules and a shadow memory; a negedge monitor compares what the DUT shows.
module tb_ram_arbiter2;

  localparam int WIDTH     = 8;
  localparam int ADDR_BITS = 11;

  logic                 clock;
  logic                 reset;
  logic                 a_req, a_we, a_ack, a_rvalid;
  logic [ADDR_BITS-1:0] a_addr;
  logic [WIDTH-1:0]     a_wdata, a_rdata;
  logic                 b_req, b_we, b_ack, b_rvalid;
  logic [ADDR_BITS-1:0] b_addr;
  logic [WIDTH-1:0]     b_wdata, b_rdata;
  logic [ADDR_BITS-1:0] ram_address;
  logic                 ram_wren;
  logic [WIDTH-1:0]     ram_write_data;
  logic [WIDTH-1:0]     ram_read_data;

  ram_arbiter2 #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_wren(ram_wren),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment RAM: write commits at the edge, read data appears two clocks later.
  logic [WIDTH-1:0] ram_mem [0:(1<<ADDR_BITS)-1];
  logic [WIDTH-1:0] rd1, rd2;
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_write_data;
    rd1 <= ram_mem[ram_address];
    rd2 <= rd1;
  end
  assign ram_read_data = rd2;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     wdata;
  } port_req_t;

  typedef struct packed {
    logic                 a_ack;
    logic                 b_ack;
    logic                 wren;
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     wdata;
  } grant_rec_t;

  typedef struct {
    logic             port;   // 0 = A, 1 = B
    logic [WIDTH-1:0] data;
    int               due;
  } read_rec_t;

  grant_rec_t       exp_grant [$];
  read_rec_t        exp_read  [$];
  logic [WIDTH-1:0] ref_mem   [0:(1<<ADDR_BITS)-1];
  logic             m_last_b;      // model: most recent grant went to B
  int               cyc;
  bit               mon_en;
  int               n_pass, n_total;

  logic [1:0]       ack_at [int];
  logic [1:0]       rv_at  [int];
  logic [WIDTH-1:0] ard_at [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic port_req_t mk(input logic v, input logic we,
                                   input logic [ADDR_BITS-1:0] addr, input logic [WIDTH-1:0] d);
    port_req_t p;
    p.valid = v;
    p.we    = we;
    p.addr  = addr;
    p.wdata = d;
    return p;
  endfunction

  function automatic logic [ADDR_BITS-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return {ADDR_BITS{1'b1}};
    return ADDR_BITS'($urandom_range(0, 15));
  endfunction

  // One clock of stimulus plus the model's prediction for that cycle.
  task automatic step(input logic rst, input port_req_t pa, input port_req_t pb,
                      output logic ga, output logic gb);
    grant_rec_t rec;
    port_req_t  win;
    read_rec_t  rr;
    @(posedge clock);
    #1;
    cyc++;
    reset   = rst;
    a_req   = pa.valid;
    a_we    = pa.valid ? pa.we    : 1'($urandom_range(0, 1));
    a_addr  = pa.valid ? pa.addr  : ADDR_BITS'($urandom);
    a_wdata = pa.valid ? pa.wdata : WIDTH'($urandom);
    b_req   = pb.valid;
    b_we    = pb.valid ? pb.we    : 1'($urandom_range(0, 1));
    b_addr  = pb.valid ? pb.addr  : ADDR_BITS'($urandom);
    b_wdata = pb.valid ? pb.wdata : WIDTH'($urandom);

    ga = 1'b0;
    gb = 1'b0;
    if (!rst) begin
      if (pa.valid && pb.valid) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = pa.valid;
        gb = pb.valid;
      end
    end

    rec = '0;
    win = ga ? pa : pb;
    if (ga || gb) begin
      rec.a_ack = ga;
      rec.b_ack = gb;
      rec.wren  = win.we;
      rec.addr  = win.addr;
      rec.wdata = win.wdata;
    end
    exp_grant.push_back(rec);

    if (rst) begin
      m_last_b = 1'b1;
      while (exp_read.size() > 0 && exp_read[$].due > cyc) void'(exp_read.pop_back());
    end else begin
      mon_en = 1'b1;
      if (ga || gb) begin
        m_last_b = gb;
        if (win.we) begin
          ref_mem[win.addr] = win.wdata;
        end else begin
          rr.port = gb;
          rr.data = ref_mem[win.addr];
          rr.due  = cyc + 2;
          exp_read.push_back(rr);
        end
      end
    end
  endtask

  // Monitor: compares one grant record per cycle and pops read records on rvalid.
  always @(negedge clock) begin
    grant_rec_t g;
    read_rec_t  r;
    if (exp_grant.size() > 0) begin
      g = exp_grant.pop_front();
      check("grant", {a_ack, b_ack, ram_wren, ram_address, ram_write_data}, g);
      ack_at[cyc] = {a_ack, b_ack};
      rv_at[cyc]  = {a_rvalid, b_rvalid};
      ard_at[cyc] = a_rdata;
      if (mon_en) begin
        check("rvalid_exclusive", a_rvalid & b_rvalid, 0);
        if (a_rvalid || b_rvalid) begin
          if (exp_read.size() == 0) begin
            check("spurious_rvalid", {a_rvalid, b_rvalid}, 0);
          end else begin
            r = exp_read.pop_front();
            check("read_port", {a_rvalid, b_rvalid}, r.port ? 2'b01 : 2'b10);
            check("read_data", r.port ? b_rdata : a_rdata, r.data);
            check("read_cycle", cyc, r.due);
          end
        end else if (exp_read.size() > 0 && exp_read[0].due <= cyc) begin
          r = exp_read.pop_front();
          check("missing_rvalid", {a_rvalid, b_rvalid}, r.port ? 2'b01 : 2'b10);
        end
        if (!a_rvalid) check("a_rdata_idle", a_rdata, 0);
        if (!b_rvalid) check("b_rdata_idle", b_rdata, 0);
      end
    end
  end

  initial begin
    port_req_t idle, pa, pb;
    logic      ga, gb, rst;
    int        c0;

    n_pass = 0; n_total = 0; cyc = 0; mon_en = 1'b0; m_last_b = 1'b1;
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < (1 << ADDR_BITS); i++) begin
      ram_mem[i] = WIDTH'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    idle = mk(1'b0, 1'b0, '0, '0);

    step(1'b1, idle, idle, ga, gb);
    step(1'b1, idle, idle, ga, gb);

    // Idle cycle: RAM outputs and acks all zero.
    step(1'b0, idle, idle, ga, gb);

    // A writes 0x5A to 0x010 then reads it back.
    c0 = cyc + 1;
    step(1'b0, mk(1'b1, 1'b1, 11'h010, 8'h5A), idle, ga, gb);
    step(1'b0, mk(1'b1, 1'b0, 11'h010, 8'h00), idle, ga, gb);
    repeat (3) step(1'b0, idle, idle, ga, gb);
    check("wr_rd_acks", {ack_at[c0], ack_at[c0+1]}, 4'b10_10);
    check("wr_rd_rvalid", {rv_at[c0+1], rv_at[c0+2], rv_at[c0+3], rv_at[c0+4]}, 8'b00_00_10_00);
    check("wr_rd_rdata", ard_at[c0+3], 8'h5A);

    // After reset, both request for 4 cycles: A, B, A, B.
    step(1'b1, idle, idle, ga, gb);
    c0 = cyc + 1;
    for (int i = 0; i < 4; i++)
      step(1'b0, mk(1'b1, 1'b0, rand_addr(), '0), mk(1'b1, 1'b0, rand_addr(), '0), ga, gb);
    repeat (3) step(1'b0, idle, idle, ga, gb);
    check("rr_order", {ack_at[c0], ack_at[c0+1], ack_at[c0+2], ack_at[c0+3]}, 8'b10_01_10_01);

    // B alone reads 0x7FF three cycles in a row.
    c0 = cyc + 1;
    for (int i = 0; i < 3; i++) step(1'b0, idle, mk(1'b1, 1'b0, 11'h7FF, '0), ga, gb);
    repeat (3) step(1'b0, idle, idle, ga, gb);
    check("b_burst_rvalid", {rv_at[c0+1], rv_at[c0+2], rv_at[c0+3], rv_at[c0+4], rv_at[c0+5]},
          10'b00_01_01_01_00);

    // A read granted, then reset: the read is discarded.
    c0 = cyc + 1;
    step(1'b0, mk(1'b1, 1'b0, 11'h123, '0), idle, ga, gb);
    step(1'b1, idle, idle, ga, gb);
    repeat (3) step(1'b0, idle, idle, ga, gb);
    check("reset_flush", {ack_at[c0], rv_at[c0+2], rv_at[c0+3]}, 6'b10_00_00);

    // last = LAST_A: B write 0xC3 to 0x020 wins, A's pending read of 0x020 follows.
    step(1'b0, mk(1'b1, 1'b0, 11'h055, '0), idle, ga, gb);
    c0 = cyc + 1;
    pa = mk(1'b1, 1'b0, 11'h020, '0);
    step(1'b0, pa, mk(1'b1, 1'b1, 11'h020, 8'hC3), ga, gb);
    step(1'b0, pa, idle, ga, gb);
    repeat (4) step(1'b0, idle, idle, ga, gb);
    check("contend_order", {ack_at[c0], ack_at[c0+1]}, 4'b01_10);
    check("contend_rdata", {rv_at[c0+3], ard_at[c0+3]}, {2'b10, 8'hC3});

    // Randomized traffic with occasional resets; requests held until granted.
    pa = idle;
    pb = idle;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!pa.valid && $urandom_range(0, 2) != 0)
        pa = mk(1'b1, 1'($urandom_range(0, 1)), rand_addr(), WIDTH'($urandom));
      if (!pb.valid && $urandom_range(0, 2) != 0)
        pb = mk(1'b1, 1'($urandom_range(0, 1)), rand_addr(), WIDTH'($urandom));
      step(rst, pa, pb, ga, gb);
      if (ga) pa.valid = 1'b0;
      if (gb) pb.valid = 1'b0;
    end
    repeat (4) step(1'b0, idle, idle, ga, gb);
    @(negedge clock);
    #1;
    check("reads_drained", exp_read.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter2.md
RAM_ARBITER2 -- requirements
Module: ram_arbiter2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of both ports and of the RAM.
REQ-002 SHALL have parameter ADDR_BITS, default 11, address width of both ports and of the RAM.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_req/b_req  input  1  access request, held high until the matching ack.
REQ-006 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have ports a_addr/b_addr  input  ADDR_BITS  word address.
REQ-008 SHALL have ports a_wdata/b_wdata  input  WIDTH  write data.
REQ-009 SHALL have ports a_ack/b_ack  output  1  combinational; high in the cycle the request is granted.
REQ-010 SHALL have ports a_rvalid/b_rvalid  output  1  registered; read data valid for that port.
REQ-011 SHALL have ports a_rdata/b_rdata  output  WIDTH  read data; 0 when that port's rvalid is low.
REQ-012 SHALL have port ram_address  output  ADDR_BITS  address to the single-port RAM.
REQ-013 SHALL have port ram_wren  output  1  write enable to the RAM.
REQ-014 SHALL have port ram_write_data  output  WIDTH  write data to the RAM.
REQ-015 SHALL have port ram_read_data  input  WIDTH  RAM read data; valid 2 clocks after address/wren are presented.

Function
REQ-016 SHALL grant at most one port per cycle; a grant is the same-cycle assertion of ack.
REQ-017 SHALL grant the only requesting port when exactly one req is high.
REQ-018 SHALL, when both req are high, grant the port not granted most recently (round-robin).
REQ-019 SHALL hold a one-bit last-grant state (LAST_A, LAST_B); it updates only on a grant.
REQ-020 SHALL drive ram_address, ram_wren (= we), ram_write_data from the granted port in the grant cycle.
REQ-021 SHALL drive ram_address = 0, ram_wren = 0, ram_write_data = 0 in cycles with no grant.
REQ-022 SHALL track reads through a 2-stage tag pipeline (valid, owner), advanced every clock.
REQ-023 SHALL assert the owner's rvalid for exactly one cycle, 2 cycles after a read grant (granted cycle t, rvalid in cycle t+2).
REQ-024 SHALL present ram_read_data on the owner's rdata while its rvalid is high.
REQ-025 SHALL never assert rvalid for a write grant.
REQ-026 SHALL accept back-to-back grants every cycle with no bubbles; throughput is 1 access/cycle.
REQ-027 SHALL keep read results in grant order; a_rvalid and b_rvalid are never high together.
REQ-028 SHALL rely on RAM ordering for write-then-read to the same address in consecutive cycles; the read returns the new data.
REQ-029 SHALL ignore we/addr/wdata of a port whose req is low.

Reset
REQ-030 SHALL, on reset high at a rising edge, set last-grant to LAST_B, so port A wins the first contention.
REQ-031 SHALL, on reset, clear both tag stages; a_rvalid = b_rvalid = 0 and rdata = 0 from the next cycle.
REQ-032 SHALL suppress ack and all RAM outputs (0) while reset is high, and discard reads in flight when reset is asserted.

Verification
REQ-033 SHALL test: A writes 0x5A to addr 0x010 in cycle 0, A reads 0x010 in cycle 1 -> a_ack high both cycles; a_rvalid only in cycle 3 with a_rdata = 0x5A.
REQ-034 SHALL test: after reset, A and B both request for 4 cycles -> grants A,B,A,B.
REQ-035 SHALL test: B alone reads 0x7FF for 3 consecutive cycles -> b_rvalid high in cycles 2,3,4; a_rvalid stays 0.
REQ-036 SHALL test: A read granted in cycle 0, reset high in cycle 1 -> no a_rvalid in cycles 2-3; all outputs 0.
REQ-037 SHALL test: idle cycle, no req -> ram_wren = 0, ram_address = 0, ram_write_data = 0, acks 0.
REQ-038 SHALL test: B write to 0x020 (0xC3) and A read of 0x020 pending together with last = LAST_A -> B granted first, A granted next cycle; a_rdata = 0xC3.
